// File: rtl/instr_fetch_loader.sv
// Program memory for the single-cycle core: byte-stream loader plus
// combinational instruction fetch; holds the core in reset until loaded.
//
// Ports:
//   clk, reset        clock, async active-low reset
//   pc_in             core byte address
//   instr_out         fetched instruction (NOP when invalid)
//   ld_valid/ld_ready byte handshake; ld_byte data, ld_last end of image
//   reload            re-enter LOAD from RUN
//   core_hold         registered; 1 holds the core in reset
//   load_done         high in RUN
//   word_count        words written in the current image
//   err_overflow      sticky byte-after-full flag
//   err_fetch         misaligned or out-of-range fetch in RUN
module instr_fetch_loader #(
   parameter int          DEPTH  = 64,
   parameter int          ADDR_W = 6,
   parameter logic [31:0] NOP    = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       pc_in,
   output logic [31:0]       instr_out,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [7:0]        ld_byte,
   input  logic              ld_last,
   input  logic              reload,
   output logic              core_hold,
   output logic              load_done,
   output logic [ADDR_W:0]   word_count,
   output logic              err_overflow,
   output logic              err_fetch
);

   typedef enum logic {
      S_LOAD,
      S_RUN
   } state_t;

   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

   state_t            state_q, state_d;
   logic [1:0]        bidx_q, bidx_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [23:0]       part_q, part_d;
   logic              ovf_q, ovf_d;
   logic              hold_q, hold_d;
   logic              we;
   logic [31:0]       wdata;
   logic [31:0]       mem_q [DEPTH];

   logic              full;
   logic              aligned;
   logic              in_range;
   logic [ADDR_W-1:0] widx;

   assign full = (cnt_q == FULL);

   // Word as it would look if written now: current byte in its lane,
   // earlier lanes from the partial register, higher lanes zero.
   always_comb begin
      wdata = 32'h0;
      unique case (bidx_q)
         2'd0: wdata = {24'h0, ld_byte};
         2'd1: wdata = {16'h0, ld_byte, part_q[7:0]};
         2'd2: wdata = {8'h0, ld_byte, part_q[15:0]};
         default: wdata = {ld_byte, part_q};
      endcase
   end

   always_comb begin
      state_d = state_q;
      bidx_d  = bidx_q;
      cnt_d   = cnt_q;
      part_d  = part_q;
      ovf_d   = ovf_q;
      hold_d  = hold_q;
      we      = 1'b0;
      unique case (state_q)
         S_LOAD: begin
            if (ld_valid) begin
               if (full) begin
                  ovf_d = 1'b1;
               end else if (bidx_q == 2'd3 || ld_last) begin
                  we     = 1'b1;
                  cnt_d  = cnt_q + 1'b1;
                  bidx_d = 2'd0;
                  part_d = 24'h0;
               end else begin
                  bidx_d = bidx_q + 2'd1;
                  unique case (bidx_q)
                     2'd0: part_d[7:0] = ld_byte;
                     2'd1: part_d[15:8] = ld_byte;
                     default: part_d[23:16] = ld_byte;
                  endcase
               end
               if (ld_last) begin
                  state_d = S_RUN;
                  hold_d  = 1'b0;
               end
            end
         end
         default: begin
            if (reload) begin
               state_d = S_LOAD;
               hold_d  = 1'b1;
               cnt_d   = '0;
               bidx_d  = 2'd0;
               part_d  = 24'h0;
               ovf_d   = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_LOAD;
         bidx_q  <= 2'd0;
         cnt_q   <= '0;
         part_q  <= 24'h0;
         ovf_q   <= 1'b0;
         hold_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         bidx_q  <= bidx_d;
         cnt_q   <= cnt_d;
         part_q  <= part_d;
         ovf_q   <= ovf_d;
         hold_q  <= hold_d;
      end
   end

   // Contents are intentionally unreset; validity comes from cnt_q.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[cnt_q[ADDR_W-1:0]] <= wdata;
      end
   end

   assign widx     = pc_in[ADDR_W+1:2];
   assign aligned  = (pc_in[1:0] == 2'b00);
   assign in_range = (pc_in[31:ADDR_W+2] == '0);

   always_comb begin
      instr_out = NOP;
      err_fetch = 1'b0;
      if (state_q == S_RUN) begin
         err_fetch = !(aligned && in_range);
         if (aligned && in_range && ({1'b0, widx} < cnt_q)) begin
            instr_out = mem_q[widx];
         end
      end
   end

   assign ld_ready     = (state_q == S_LOAD);
   assign load_done    = (state_q == S_RUN);
   assign core_hold    = hold_q;
   assign word_count   = cnt_q;
   assign err_overflow = ovf_q;

endmodule

// File: tb/tb_instr_fetch_loader.sv
// Scoreboard bench for instr_fetch_loader: loads images, queues expected
// words from a byte-level model, and pops them against fetches in RUN.
module tb_instr_fetch_loader;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc_in = 32'h0;
   logic [31:0] instr_out;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [7:0]  ld_byte = 8'h0;
   logic        ld_last = 1'b0;
   logic        reload = 1'b0;
   logic        core_hold;
   logic        load_done;
   logic [6:0]  word_count;
   logic        err_overflow;
   logic        err_fetch;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   logic [31:0] m_word;
   int          m_lane;
   int          m_cnt;
   logic        m_ovf;
   logic        m_run;

   instr_fetch_loader dut (
      .clk(clk),
      .reset(reset),
      .pc_in(pc_in),
      .instr_out(instr_out),
      .ld_valid(ld_valid),
      .ld_ready(ld_ready),
      .ld_byte(ld_byte),
      .ld_last(ld_last),
      .reload(reload),
      .core_hold(core_hold),
      .load_done(load_done),
      .word_count(word_count),
      .err_overflow(err_overflow),
      .err_fetch(err_fetch)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_word = 32'h0;
      m_lane = 0;
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_run  = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input logic last);
      @(negedge clk);
      ld_valid = 1'b1;
      ld_byte  = b;
      ld_last  = last;
      @(posedge clk);
      if (!m_run) begin
         if (m_cnt == 64) begin
            m_ovf = 1'b1;
         end else begin
            m_word = m_word | (32'(b) << (8 * m_lane));
            if (m_lane == 3 || last) begin
               exp_q.push_back(m_word);
               m_cnt++;
               m_word = 32'h0;
               m_lane = 0;
            end else begin
               m_lane++;
            end
         end
         if (last) m_run = 1'b1;
      end
      #1;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         ld_valid = 1'b0;
         ld_byte  = 8'($urandom);
         ld_last  = 1'($urandom);
      end
      @(negedge clk);
      ld_last = 1'b0;
   endtask

   task automatic do_reload();
      @(negedge clk);
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
      model_clear();
   endtask

   task automatic verify_all(input string tag);
      int n;
      logic [31:0] w;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         w = exp_q.pop_front();
         pc_in = 32'(4 * i);
         #1;
         chk(tag, instr_out, w);
         chk({tag, "_err"}, 32'(err_fetch), 32'h0);
      end
   endtask

   task automatic fetch(input string tag, input logic [31:0] pc,
                        input logic [31:0] ins, input logic ef);
      pc_in = pc;
      #1;
      chk(tag, instr_out, ins);
      chk({tag, "_err"}, 32'(err_fetch), 32'(ef));
   endtask

   initial begin
      logic [7:0] img1[8];
      logic [7:0] img2[5];
      img1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
      img2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      model_clear();

      #12;
      chk("rst_hold", 32'(core_hold), 32'h1);
      chk("rst_done", 32'(load_done), 32'h0);
      chk("rst_ready", 32'(ld_ready), 32'h1);
      chk("rst_wc", 32'(word_count), 32'h0);
      chk("rst_ovf", 32'(err_overflow), 32'h0);
      chk("rst_instr", instr_out, NOP);
      @(negedge clk);
      reset = 1'b1;

      // 1: two-word image
      for (int i = 0; i < 8; i++) send(img1[i], i == 7);
      @(negedge clk);
      chk("t1_wc", 32'(word_count), 32'd2);
      chk("t1_done", 32'(load_done), 32'h1);
      chk("t1_hold", 32'(core_hold), 32'h0);
      fetch("t1_pc0", 32'h0, 32'h0000_0013, 1'b0);
      fetch("t1_pc4", 32'h4, 32'h0050_0093, 1'b0);
      verify_all("t1_sb");

      // 2: partial final word
      do_reload();
      chk("t2_hold", 32'(core_hold), 32'h1);
      chk("t2_wc0", 32'(word_count), 32'h0);
      for (int i = 0; i < 5; i++) send(img2[i], i == 4);
      @(negedge clk);
      chk("t2_wc", 32'(word_count), 32'd2);
      fetch("t2_pc4", 32'h4, 32'h0000_00EE, 1'b0);
      fetch("t2_pc8", 32'h8, NOP, 1'b0);
      verify_all("t2_sb");

      // 4: bad fetches with two words loaded
      fetch("t4_mis", 32'h2, NOP, 1'b1);
      fetch("t4_oor", 32'h100, NOP, 1'b1);
      fetch("t4_fc", 32'hFC, NOP, 1'b0);
      fetch("t4_hi", 32'h8000_0000, NOP, 1'b1);

      // 3: randomized stalls, idle cycles carry junk and ld_last
      do_reload();
      for (int i = 0; i < 16; i++) begin
         idle($urandom_range(0, 3));
         send(8'($urandom), i == 15);
      end
      @(negedge clk);
      chk("t3_wc", 32'(word_count), 32'd4);
      chk("t3_ready", 32'(ld_ready), 32'h0);
      // loader inputs ignored in RUN
      send(8'h77, 1'b1);
      chk("t3_wc_run", 32'(word_count), 32'd4);
      verify_all("t3_sb");

      // 5: overflow
      do_reload();
      for (int i = 0; i < 4 * 64 + 3; i++) begin
         send(8'(i) ^ 8'h5A, i == 4 * 64 + 2);
      end
      @(negedge clk);
      chk("t5_wc", 32'(word_count), 32'(m_cnt));
      chk("t5_wc64", 32'(word_count), 32'd64);
      chk("t5_ovf", 32'(err_overflow), 32'(m_ovf));
      chk("t5_done", 32'(load_done), 32'h1);
      verify_all("t5_sb");
      do_reload();
      chk("t5_ovf_clr", 32'(err_overflow), 32'h0);
      chk("t5_wc_clr", 32'(word_count), 32'h0);
      chk("t5_hold", 32'(core_hold), 32'h1);

      // 6: reset mid-load
      for (int i = 0; i < 6; i++) send(8'(8'h10 + i), 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      model_clear();
      chk("t6_wc", 32'(word_count), 32'h0);
      chk("t6_hold", 32'(core_hold), 32'h1);
      chk("t6_ready", 32'(ld_ready), 32'h1);
      @(negedge clk);
      reset = 1'b1;
      send(8'h21, 1'b0);
      send(8'h43, 1'b0);
      send(8'h65, 1'b0);
      send(8'h87, 1'b1);
      @(negedge clk);
      chk("t6_wc1", 32'(word_count), 32'd1);
      fetch("t6_pc0", 32'h0, 32'h8765_4321, 1'b0);
      verify_all("t6_sb");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
